// File: rtl/fifo_uart_transmitter_if.sv
// Handshake and serial-line bundle between a FIFO and its UART drain stage.
interface fifo_uart_transmitter_if #(
  parameter int unsigned Input_Data_Width = 8
);
  logic                        Enable;
  logic                        FIFO_Empty;
  logic [Input_Data_Width-1:0] FIFO_Data;
  logic                        Read;
  logic                        Tx;
  logic                        Busy;
  logic                        Frame_Done;

  // Transmitter side: consumes FIFO status/data, drives pop and serial line
  modport master (
    input  Enable,
    input  FIFO_Empty,
    input  FIFO_Data,
    output Read,
    output Tx,
    output Busy,
    output Frame_Done
  );

  // FIFO/controller side
  modport slave (
    output Enable,
    output FIFO_Empty,
    output FIFO_Data,
    input  Read,
    input  Tx,
    input  Busy,
    input  Frame_Done
  );
endinterface

// File: rtl/fifo_uart_transmitter.sv
// FIFO drain stage: pops one word at a time and serializes it as a UART frame
// (start bit, data LSB-first, optional even parity, 1 or 2 stop bits).
module fifo_uart_transmitter #(
  parameter int unsigned Input_Data_Width = 8,
  parameter int unsigned Clocks_Per_Bit   = 16,
  parameter int unsigned Stop_Bits        = 1,
  parameter bit          Parity_Enable    = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  fifo_uart_transmitter_if.master   bus
);

  localparam int unsigned BAUD_W = $clog2(Clocks_Per_Bit);
  localparam int unsigned BIT_W  = $clog2(Input_Data_Width + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ_REQ = 3'd1,
    S_LOAD     = 3'd2,
    S_START    = 3'd3,
    S_DATA     = 3'd4,
    S_PARITY   = 3'd5,
    S_STOP     = 3'd6
  } state_t;

  state_t                      r_state;
  logic [BAUD_W-1:0]           r_baud;
  logic [BIT_W-1:0]            r_bit;
  logic [Input_Data_Width-1:0] r_shift;
  logic                        r_parity;

  logic                        r_read;
  logic                        r_tx;
  logic                        r_busy;
  logic                        r_done;

  state_t                      w_state_next;
  logic [BAUD_W-1:0]           w_baud_next;
  logic [BIT_W-1:0]            w_bit_next;
  logic [Input_Data_Width-1:0] w_shift_next;
  logic                        w_parity_next;

  logic                        w_read_next;
  logic                        w_tx_next;
  logic                        w_busy_next;
  logic                        w_done_next;

  logic                        w_baud_last;
  logic                        w_data_last;
  logic                        w_stop_last;

  assign w_baud_last = (r_baud == BAUD_W'(Clocks_Per_Bit - 1));
  assign w_data_last = (r_bit == BIT_W'(Input_Data_Width - 1));
  assign w_stop_last = (r_bit == BIT_W'(Stop_Bits - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_baud   <= w_baud_next;
      r_bit    <= w_bit_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
    end
  end

  // Next-state decode; Enable and FIFO_Empty only matter in IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.Enable && !bus.FIFO_Empty) w_state_next = S_READ_REQ;
      S_READ_REQ: w_state_next = S_LOAD;
      S_LOAD:     w_state_next = S_START;
      S_START:    if (w_baud_last) w_state_next = S_DATA;
      S_DATA: begin
        if (w_baud_last && w_data_last) begin
          w_state_next = Parity_Enable ? S_PARITY : S_STOP;
        end
      end
      S_PARITY:   if (w_baud_last) w_state_next = S_STOP;
      S_STOP:     if (w_baud_last && w_stop_last) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Baud/bit counters restart on every state change; shift reg loads in LOAD
  always_comb begin
    w_baud_next   = r_baud;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    if (w_state_next != r_state) begin
      w_baud_next = '0;
      w_bit_next  = '0;
    end else if (r_state inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
      w_baud_next = w_baud_last ? '0 : r_baud + BAUD_W'(1);
      if (w_baud_last && (r_state inside {S_DATA, S_STOP})) begin
        w_bit_next = r_bit + BIT_W'(1);
      end
    end
    if (r_state == S_LOAD) begin
      w_shift_next  = bus.FIFO_Data;
      w_parity_next = ^bus.FIFO_Data;
    end else if ((r_state == S_DATA) && w_baud_last) begin
      w_shift_next = r_shift >> 1;
    end
  end

  // Output decode from the upcoming state so registered outputs align with it
  always_comb begin
    w_read_next = 1'b0;
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = 1'b0;
    case (w_state_next)
      S_READ_REQ: w_read_next = 1'b1;
      S_START:    w_tx_next   = 1'b0;
      S_DATA:     w_tx_next   = w_shift_next[0];
      S_PARITY:   w_tx_next   = w_parity_next;
      S_STOP: begin
        w_done_next = (w_baud_next == BAUD_W'(Clocks_Per_Bit - 1)) &&
                      (w_bit_next == BIT_W'(Stop_Bits - 1));
      end
      default:    w_tx_next   = 1'b1;
    endcase
  end

  // Output registers; reset forces the line idle high immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read <= 1'b0;
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_read <= w_read_next;
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
    end
  end

  assign bus.Read       = r_read;
  assign bus.Tx         = r_tx;
  assign bus.Busy       = r_busy;
  assign bus.Frame_Done = r_done;

endmodule

// File: tb/tb_fifo_uart_transmitter.sv
// Bench for fifo_uart_transmitter: three instances (no parity/1 stop,
// parity/1 stop, parity/2 stops), FIFO models, and per-instance frame monitors.
module tb_fifo_uart_transmitter;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  fifo_uart_transmitter_if #(.Input_Data_Width(8)) if_a ();
  fifo_uart_transmitter_if #(.Input_Data_Width(8)) if_b ();
  fifo_uart_transmitter_if #(.Input_Data_Width(8)) if_c ();

  fifo_uart_transmitter #(.Input_Data_Width(8), .Clocks_Per_Bit(4), .Stop_Bits(1), .Parity_Enable(1'b0))
    u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
  fifo_uart_transmitter #(.Input_Data_Width(8), .Clocks_Per_Bit(4), .Stop_Bits(1), .Parity_Enable(1'b1))
    u_dut_b (.clk(clk), .reset(reset), .bus(if_b));
  fifo_uart_transmitter #(.Input_Data_Width(8), .Clocks_Per_Bit(4), .Stop_Bits(2), .Parity_Enable(1'b1))
    u_dut_c (.clk(clk), .reset(reset), .bus(if_c));

  logic [2:0] tx_w, done_w, busy_w, read_w, emp_w;
  assign tx_w   = {if_c.Tx, if_b.Tx, if_a.Tx};
  assign done_w = {if_c.Frame_Done, if_b.Frame_Done, if_a.Frame_Done};
  assign busy_w = {if_c.Busy, if_b.Busy, if_a.Busy};
  assign read_w = {if_c.Read, if_b.Read, if_a.Read};
  assign emp_w  = {if_c.FIFO_Empty, if_b.FIFO_Empty, if_a.FIFO_Empty};

  // FIFO contents and expected frames {parity, data}
  logic [7:0] fq0[$], fq1[$], fq2[$];
  logic [8:0] exp0[$], exp1[$], exp2[$];
  int         rdq0[$];
  int         last_rd[3];
  logic [2:0] prev_rd, prev_emp;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  function automatic int exp_size(input int idx);
    case (idx)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  task automatic exp_pop(input int idx, output logic [8:0] e);
    case (idx)
      0: e = exp0.pop_front();
      1: e = exp1.pop_front();
      default: e = exp2.pop_front();
    endcase
  endtask

  // Non-showahead FIFO: a Read pulse presents the popped word on the next cycle
  always @(posedge clk) begin : fifo_model
    logic [7:0] w;
    if (if_a.Read && fq0.size() > 0) begin w = fq0.pop_front(); if_a.FIFO_Data <= w; end
    if (if_b.Read && fq1.size() > 0) begin w = fq1.pop_front(); if_b.FIFO_Data <= w; end
    if (if_c.Read && fq2.size() > 0) begin w = fq2.pop_front(); if_c.FIFO_Data <= w; end
    if_a.FIFO_Empty <= (fq0.size() == 0);
    if_b.FIFO_Empty <= (fq1.size() == 0);
    if_c.FIFO_Empty <= (fq2.size() == 0);
  end

  // Read pulses must be isolated and never follow an empty IDLE decision cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (read_w[i]) begin
        chk($sformatf("dut%0d_read_back_to_back", i), int'(prev_rd[i]), 0);
        chk($sformatf("dut%0d_read_when_empty", i), int'(prev_emp[i]), 0);
        last_rd[i] = cyc;
        if (i == 0) rdq0.push_back(cyc);
      end
    end
    prev_rd  = read_w;
    prev_emp = emp_w;
  end

  task automatic wait_cyc(input int t, inout bit ab);
    while (cyc < t && !ab) begin
      @(negedge clk);
      if (!reset) ab = 1'b1;
    end
  endtask

  // Frame monitor: samples each bit mid-period, checks Frame_Done/Busy timing
  task automatic mon(input int idx, input int par_en, input int stops, input int flen);
    int         c0, n;
    bit         ab;
    logic [7:0] d;
    logic       p, sb, stop_ok, d_pre, d_last, b_after;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx_w[idx] === 1'b0) begin
        c0 = cyc; ab = 1'b0; d = '0; p = 1'b0; stop_ok = 1'b1;
        sb = 1'b1; d_pre = 1'b1; d_last = 1'b0; b_after = 1'b1;
        chk($sformatf("dut%0d_read_to_start", idx), c0 - last_rd[idx], 2);
        wait_cyc(c0 + 2, ab);
        sb = tx_w[idx];
        for (int b = 0; b < 8; b++) begin
          if (!ab) begin wait_cyc(c0 + 4 * (b + 1) + 2, ab); d[b] = tx_w[idx]; end
        end
        if (!ab && par_en != 0) begin wait_cyc(c0 + 38, ab); p = tx_w[idx]; end
        for (int s = 0; s < stops; s++) begin
          if (!ab) begin
            wait_cyc(c0 + 4 * (9 + par_en + s) + 2, ab);
            if (tx_w[idx] !== 1'b1) stop_ok = 1'b0;
          end
        end
        if (!ab) begin wait_cyc(c0 + flen - 2, ab); d_pre   = done_w[idx]; end
        if (!ab) begin wait_cyc(c0 + flen - 1, ab); d_last  = done_w[idx]; end
        if (!ab) begin wait_cyc(c0 + flen, ab);     b_after = busy_w[idx]; end
        if (!ab) begin
          n = exp_size(idx);
          chk($sformatf("dut%0d_frame_expected", idx), n > 0 ? 1 : 0, 1);
          if (n > 0) begin
            exp_pop(idx, e);
            chk($sformatf("dut%0d_start_bit", idx), int'(sb), 0);
            chk($sformatf("dut%0d_data", idx), int'(d), int'(e[7:0]));
            if (par_en != 0) chk($sformatf("dut%0d_parity", idx), int'(p), int'(e[8]));
            chk($sformatf("dut%0d_stop_bits", idx), int'(stop_ok), 1);
            chk($sformatf("dut%0d_done_early", idx), int'(d_pre), 0);
            chk($sformatf("dut%0d_done_last_stop", idx), int'(d_last), 1);
            chk($sformatf("dut%0d_busy_after", idx), int'(b_after), 0);
          end
        end
      end
    end
  endtask

  initial mon(0, 0, 1, 40);
  initial mon(1, 1, 1, 44);
  initial mon(2, 1, 2, 48);

  task automatic wait_exp(input int idx, input int target, input int limit);
    int k;
    k = 0;
    while (exp_size(idx) > target && k < limit) begin @(negedge clk); k++; end
    chk($sformatf("dut%0d_drain_to_%0d", idx, target), exp_size(idx), target);
  endtask

  task automatic wait_start_a(input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (if_a.Tx !== 1'b0 && k < limit) begin @(negedge clk); k++; end
    chk("dutA_start_seen", int'(if_a.Tx), 0);
  endtask

  task automatic chk_idle_a(input string nm);
    chk({nm, "_tx"}, int'(if_a.Tx), 1);
    chk({nm, "_read"}, int'(if_a.Read), 0);
    chk({nm, "_busy"}, int'(if_a.Busy), 0);
    chk({nm, "_done"}, int'(if_a.Frame_Done), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0;
    if_a.Enable = 1'b1;
    if_b.Enable = 1'b1;
    if_c.Enable = 1'b1;

    // 1: reset holds everything idle even with Enable and a word available
    fq0.push_back(8'hA5);
    exp0.push_back({1'b0, 8'hA5});
    repeat (5) begin
      @(negedge clk);
      chk_idle_a("reset_hold");
    end

    // 2: single byte A5 after release
    reset = 1'b1;
    wait_exp(0, 0, 200);
    repeat (4) @(negedge clk);
    chk_idle_a("after_a5");

    // 3: three queued words, back-to-back with 43-cycle read spacing
    rdq0.delete();
    fq0.push_back(8'h10); exp0.push_back({1'b0, 8'h10});
    fq0.push_back(8'h20); exp0.push_back({1'b0, 8'h20});
    fq0.push_back(8'h30); exp0.push_back({1'b0, 8'h30});
    wait_exp(0, 0, 400);
    repeat (10) @(negedge clk);
    chk("burst_read_count", rdq0.size(), 3);
    if (rdq0.size() == 3) begin
      chk("burst_gap_1", rdq0[1] - rdq0[0], 43);
      chk("burst_gap_2", rdq0[2] - rdq0[1], 43);
    end
    chk_idle_a("burst_idle");
    chk("burst_fifo_empty", int'(if_a.FIFO_Empty), 1);

    // 4: parity of 07 is 1; 44-cycle frame with 1 stop, 48 with 2 stops
    fq1.push_back(8'h07); exp1.push_back({1'b1, 8'h07});
    fq2.push_back(8'h07); exp2.push_back({1'b1, 8'h07});
    wait_exp(1, 0, 200);
    wait_exp(2, 0, 200);

    // 5: reset during data bit 3 of FF discards it; next word sent in full
    rdq0.delete();
    fq0.push_back(8'hFF);
    fq0.push_back(8'h3C); exp0.push_back({1'b0, 8'h3C});
    wait_start_a(100);
    repeat (18) @(negedge clk);
    chk("pre_reset_in_frame_busy", int'(if_a.Busy), 1);
    reset = 1'b0;
    #1;
    chk_idle_a("mid_frame_reset");
    repeat (3) begin
      @(negedge clk);
      chk("mid_reset_no_read", int'(if_a.Read), 0);
    end
    reset = 1'b1;
    wait_exp(0, 0, 200);
    chk("reset_recover_reads", rdq0.size(), 2);

    // 6: Enable dropped during START lets the frame finish, then holds off
    repeat (5) @(negedge clk);
    rdq0.delete();
    fq0.push_back(8'h5A); exp0.push_back({1'b0, 8'h5A});
    fq0.push_back(8'hC3); exp0.push_back({1'b0, 8'hC3});
    wait_start_a(100);
    if_a.Enable = 1'b0;
    wait_exp(0, 1, 200);
    repeat (60) @(negedge clk);
    chk("disabled_read_count", rdq0.size(), 1);
    chk_idle_a("disabled_idle");
    if_a.Enable = 1'b1;
    wait_exp(0, 0, 200);
    chk("resumed_read_count", rdq0.size(), 2);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
